// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux_pkg
// Description : Shared constants and helpers for the demux_stream block.
//               MODE_SEL / MODE_RR   - inMode encodings
//               sel_width(num_ch)    - select/pointer width for num_ch outputs
// Revision    : 1.0  initial release
// ============================================================================
package demux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // A single-bit select is kept as the minimum so that the port never
    // collapses to zero width.
    function automatic int sel_width(input int num_ch);
        return (num_ch > 2) ? $clog2(num_ch) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
// Module      : demux_slot
// Description : One-entry registered output slot of the stream demux.
//   clk, rst  - clock, asynchronous active-high reset
//   i_clear   - synchronous clear of the valid flag (data is kept)
//   i_load    - write i_data into the slot and mark it valid
//   i_drain   - downstream consumes the slot this cycle
//   i_data    - word to load
//   o_valid   - slot holds a word
//   o_data    - stored word (holds last loaded value while empty)
// Revision    : 1.0  initial release
// ============================================================================
module demux_slot #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic              i_drain,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid_q;
    logic              w_valid_d;
    logic [DATA_W-1:0] r_data_q;
    logic [DATA_W-1:0] w_data_d;

    always_comb begin
        w_valid_d = r_valid_q;
        w_data_d  = r_data_q;
        if (i_clear) begin
            w_valid_d = 1'b0;
        end else if (i_load) begin
            // A load on the same edge as a drain keeps the slot occupied.
            w_valid_d = 1'b1;
            w_data_d  = i_data;
        end else if (i_drain) begin
            w_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
        end else begin
            r_valid_q <= w_valid_d;
            r_data_q  <= w_data_d;
        end
    end

    assign o_valid = r_valid_q;
    assign o_data  = r_data_q;

endmodule
`default_nettype wire

// File: rtl/demux_stream.sv
`default_nettype none
// ============================================================================
// Module      : demux_stream
// Description : 1-to-NUM_CH stream demultiplexer with valid/ready handshake,
//               a one-entry slot per channel, select or round-robin routing
//               and out-of-range detection.
//   inClk, inRst  - clock, asynchronous active-high reset
//   inClear       - synchronous clear of slots and round-robin pointer
//   inMode        - MODE_SEL: route by inSel, MODE_RR: route by pointer
//   inValid/inReady/inData/inSel - input stream and select
//   inDsReady     - per-channel downstream ready
//   outValid/outData - per-channel slot valid / packed slot data
//   outErr        - one-cycle pulse after an out-of-range word was dropped
//   outPtr        - current round-robin pointer
// Revision    : 1.0  initial release
// ============================================================================
module demux_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int NUM_CH = 8,
    parameter int SEL_W  = sel_width(NUM_CH)
) (
    input  logic                     inClk,
    input  logic                     inRst,
    input  logic                     inClear,
    input  logic                     inMode,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic [DATA_W-1:0]        inData,
    input  logic [SEL_W-1:0]         inSel,
    input  logic [NUM_CH-1:0]        inDsReady,
    output logic [NUM_CH-1:0]        outValid,
    output logic [NUM_CH*DATA_W-1:0] outData,
    output logic                     outErr,
    output logic [SEL_W-1:0]         outPtr
);

    // One extra bit so that NUM_CH itself is representable for the range test.
    localparam logic [SEL_W:0]   c_NUM_CH  = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] c_PTR_MAX = SEL_W'(NUM_CH - 1);

    logic [SEL_W-1:0]  w_tgt;
    logic              w_tgt_oor;
    logic [NUM_CH-1:0] w_tgt_hit;
    logic [NUM_CH-1:0] w_load;
    logic [NUM_CH-1:0] w_valid;
    logic              w_ready;
    logic              w_xfer;
    logic              w_err_d;
    logic              r_err_q;
    logic [SEL_W-1:0]  w_ptr_d;
    logic [SEL_W-1:0]  r_ptr_q;

    always_comb begin
        w_tgt     = (inMode == MODE_RR) ? r_ptr_q : inSel;
        w_tgt_oor = ({1'b0, w_tgt} >= c_NUM_CH);

        // One-hot target decode; all zero for an out-of-range select, which
        // makes such a word always acceptable (it is simply discarded).
        for (int c = 0; c < NUM_CH; c++) begin
            w_tgt_hit[c] = (w_tgt == SEL_W'(c));
        end

        // Stall only when the targeted slot is full and not draining.
        w_ready = !inClear && ((w_tgt_hit & w_valid & ~inDsReady) == '0);
        w_xfer  = inValid && w_ready;
        w_load  = w_xfer ? w_tgt_hit : '0;
        w_err_d = w_xfer && w_tgt_oor;

        w_ptr_d = r_ptr_q;
        if (inClear) begin
            w_ptr_d = '0;
        end else if (w_xfer && (inMode == MODE_RR)) begin
            w_ptr_d = (r_ptr_q == c_PTR_MAX) ? '0 : r_ptr_q + SEL_W'(1);
        end
    end

    always_ff @(posedge inClk or posedge inRst) begin
        if (inRst) begin
            r_ptr_q <= '0;
            r_err_q <= 1'b0;
        end else begin
            r_ptr_q <= w_ptr_d;
            r_err_q <= w_err_d;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
        demux_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk     (inClk),
            .rst     (inRst),
            .i_clear (inClear),
            .i_load  (w_load[gi]),
            .i_drain (inDsReady[gi]),
            .i_data  (inData),
            .o_valid (w_valid[gi]),
            .o_data  (outData[gi*DATA_W +: DATA_W])
        );
    end

    assign inReady  = w_ready;
    assign outValid = w_valid;
    assign outErr   = r_err_q;
    assign outPtr   = r_ptr_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_stream
// Description : Self-checking bench for demux_stream. Drives an 8-channel and
//               a 6-channel instance with the same stream and compares both
//               against a slot/pointer reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_demux_stream;

    logic       clk = 1'b0;
    logic       rst, clr, mode, valid;
    logic [3:0] data;
    logic [2:0] sel;
    logic [7:0] ds;

    logic        rdy8, rdy6, err8, err6;
    logic [7:0]  ov8;
    logic [5:0]  ov6;
    logic [31:0] od8;
    logic [23:0] od6;
    logic [2:0]  ptr8, ptr6;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    demux_stream #(.DATA_W(4), .NUM_CH(8)) u_dut8 (
        .inClk(clk), .inRst(rst), .inClear(clr), .inMode(mode),
        .inValid(valid), .inReady(rdy8), .inData(data), .inSel(sel),
        .inDsReady(ds), .outValid(ov8), .outData(od8), .outErr(err8),
        .outPtr(ptr8)
    );

    demux_stream #(.DATA_W(4), .NUM_CH(6)) u_dut6 (
        .inClk(clk), .inRst(rst), .inClear(clr), .inMode(mode),
        .inValid(valid), .inReady(rdy6), .inData(data), .inSel(sel),
        .inDsReady(ds[5:0]), .outValid(ov6), .outData(od6), .outErr(err6),
        .outPtr(ptr6)
    );

    // ---------------- reference model ----------------
    logic       mv   [2][8];
    logic [3:0] md   [2][8];
    int         mptr [2];
    logic       merr [2];
    logic       mrdy [2];

    function automatic int nch(input int k);
        return (k == 0) ? 8 : 6;
    endfunction

    function automatic int target(input int k);
        return mode ? mptr[k] : int'(sel);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 8; c++) begin
                mv[k][c] = 1'b0;
                md[k][c] = 4'h0;
            end
            mptr[k] = 0;
            merr[k] = 1'b0;
        end
    endtask

    function automatic logic exp_ready(input int k);
        int t;
        t = target(k);
        if (clr) return 1'b0;
        if (t >= nch(k)) return 1'b1;
        return !mv[k][t] || ds[t];
    endfunction

    task automatic model_step(input int k);
        int   t;
        logic acc;
        t   = target(k);
        acc = valid && mrdy[k];
        merr[k] = 1'b0;
        if (clr) begin
            for (int c = 0; c < 8; c++) mv[k][c] = 1'b0;
            mptr[k] = 0;
        end else begin
            for (int c = 0; c < nch(k); c++)
                if (mv[k][c] && ds[c]) mv[k][c] = 1'b0;
            if (acc) begin
                if (t < nch(k)) begin
                    mv[k][t] = 1'b1;
                    md[k][t] = data;
                end else begin
                    merr[k] = 1'b1;
                end
                if (mode) mptr[k] = (mptr[k] + 1) % nch(k);
            end
        end
    endtask

    function automatic logic [63:0] pack_v(input int k);
        logic [63:0] r;
        r = '0;
        for (int c = 0; c < nch(k); c++) r[c] = mv[k][c];
        return r;
    endfunction

    function automatic logic [63:0] pack_d(input int k);
        logic [63:0] r;
        r = '0;
        for (int c = 0; c < nch(k); c++) r[c*4 +: 4] = md[k][c];
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        check("valid8", 64'(ov8),  pack_v(0));
        check("data8",  64'(od8),  pack_d(0));
        check("ptr8",   64'(ptr8), 64'(mptr[0]));
        check("err8",   64'(err8), 64'(merr[0]));
        check("valid6", 64'(ov6),  pack_v(1));
        check("data6",  64'(od6),  pack_d(1));
        check("ptr6",   64'(ptr6), 64'(mptr[1]));
        check("err6",   64'(err6), 64'(merr[1]));
    endtask

    // Drive one cycle: inputs applied 1ns after an edge, inReady checked
    // before the next edge, outputs checked 1ns after it.
    task automatic cycle(input logic i_clr, input logic i_mode, input logic i_valid,
                         input logic [3:0] i_data, input logic [2:0] i_sel,
                         input logic [7:0] i_ds);
        clr = i_clr; mode = i_mode; valid = i_valid;
        data = i_data; sel = i_sel; ds = i_ds;
        #1;
        mrdy[0] = exp_ready(0);
        mrdy[1] = exp_ready(1);
        check("ready8", 64'(rdy8), 64'(mrdy[0]));
        check("ready6", 64'(rdy6), 64'(mrdy[1]));
        @(posedge clk);
        #1;
        model_step(0);
        model_step(1);
        check_outputs();
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; mode = 1'b0; valid = 1'b0;
        data = '0; sel = '0; ds = '0;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // SEL mode stepping through all channels, everything ready
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 4'(i + 1), 3'(i), 8'hFF);
            check("sel_onehot", 64'(ov8), 64'(1) << i);
            check("sel_data", 64'(od8[i*4 +: 4]), 64'(i + 1));
        end

        // Backpressure on channel 3
        cycle(1'b0, 1'b0, 1'b1, 4'hA, 3'd3, 8'hF7);
        cycle(1'b0, 1'b0, 1'b1, 4'hB, 3'd3, 8'hF7);   // stalled
        check("bp_hold", 64'(od8[15:12]), 64'hA);
        check("bp_stall", 64'(mrdy[0]), 64'(rdy8 & 1'b0));
        cycle(1'b0, 1'b0, 1'b1, 4'hC, 3'd5, 8'hF7);   // other channel flows
        check("bp_ch5", 64'(ov8[5]), 64'h1);
        cycle(1'b0, 1'b0, 1'b1, 4'hB, 3'd3, 8'hFF);   // drain A, load B
        check("bp_refill", 64'(od8[15:12]), 64'hB);
        check("bp_valid3", 64'(ov8[3]), 64'h1);

        // Round-robin: 10 words
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 4'(i), 3'd0, 8'hFF);
            check("rr_data", 64'(od8[(i % 8)*4 +: 4]), 64'(i));
        end
        check("rr_ptr", 64'(ptr8), 64'd2);
        cycle(1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 8'hFF);
        check("rr_hold", 64'(ptr8), 64'd2);

        // Out-of-range select on the 6-channel instance
        cycle(1'b0, 1'b0, 1'b1, 4'h6, 3'd7, 8'hFF);
        check("oor_err", 64'(err6), 64'h1);
        check("oor_novalid", 64'(ov6), 64'h0);
        cycle(1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 8'hFF);
        check("oor_pulse", 64'(err6), 64'h0);

        // Clear while slots 1 and 4 are full, with a word offered
        cycle(1'b0, 1'b0, 1'b1, 4'h3, 3'd1, 8'h00);
        cycle(1'b0, 1'b0, 1'b1, 4'h9, 3'd4, 8'h00);
        check("pre_clear", 64'(ov8), 64'h12);
        cycle(1'b1, 1'b0, 1'b1, 4'hF, 3'd2, 8'h00);
        check("clear_valid", 64'(ov8), 64'h0);
        check("clear_ptr", 64'(ptr8), 64'h0);

        // Asynchronous reset mid-stream in RR mode
        cycle(1'b0, 1'b1, 1'b1, 4'h7, 3'd0, 8'h00);
        cycle(1'b0, 1'b1, 1'b1, 4'h8, 3'd0, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1'b0, 1'b1, 1'b1, 4'h5, 3'd0, 8'h00);
        check("post_rst_ch0", 64'(ov8), 64'h1);
        check("post_rst_data", 64'(od8[3:0]), 64'h5);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            cycle(($urandom % 20) == 0, 1'($urandom), ($urandom % 4) != 0,
                  4'($urandom), 3'($urandom), 8'($urandom | $urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
